apb_requester: RTL
==================

Name: apb_requester

Overview:
- APB initiator that turns a simple valid/ready command stream into APB3 transfers (SETUP then ACCESS) and returns read data and error status on a valid/ready response stream.
- Drives the existing APB-to-I2C completer (TX FIFO 0x0, RX FIFO 0x4, CONFIG 0x8, TIMEOUT 0xC) from an internal controller or test sequencer.
- Handles one transfer at a time; no pipelining across transfers.

Parameters:
- ADDR_W, 32, PADDR width.
- DATA_W, 32, PWDATA/PRDATA width.
- TIMEOUT_CYCLES, 16, max ACCESS cycles waiting for PREADY (used only with the optional feature); must be >= 1.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data (ignored for reads).
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  completer ready.
- PSLVERR  in  1  completer error, sampled only with PREADY.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_W  read data (0 for writes).
- rsp_err  out  1  PSLVERR captured, or timeout.
- rsp_timeout  out  1  transfer aborted by watchdog (0 when the feature is compiled out).
- busy  out  1  state != IDLE.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0, cmd_ready 0 during reset, state IDLE.
- States and transitions:
  - IDLE -> SETUP on cmd_valid && cmd_ready; cmd_ready = 1 only in IDLE.
  - On acceptance, latch cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA. These hold stable through SETUP and ACCESS.
  - SETUP: PSELx = 1, PENABLE = 0; always one cycle, then ACCESS.
  - ACCESS: PSELx = 1, PENABLE = 1.
    - On a PCLK edge with PREADY = 1: capture PRDATA (reads only, else 0) into rsp_rdata and PSLVERR into rsp_err, then go to RESP.
    - PREADY = 0: stay in ACCESS, outputs unchanged.
  - RESP: PSELx = 0, PENABLE = 0, rsp_valid = 1; data held until rsp_valid && rsp_ready, then IDLE.
- Latency: command accepted at edge N -> SETUP in cycle N+1 -> ACCESS in N+2 -> with zero wait states, rsp_valid in N+3. Next command can be accepted no earlier than the cycle after the response handshake.
- PADDR/PWRITE/PWDATA keep their last values in IDLE/RESP (no glitching to 0). PSELx and PENABLE are 0 outside SETUP/ACCESS.
- A new cmd_valid while busy is ignored (cmd_ready = 0). The command source must hold its fields until accepted.
- rsp_ready held high in RESP: handshake completes in the first RESP cycle.
- Reset in any state, including mid-ACCESS: next cycle IDLE, PSELx/PENABLE/rsp_valid = 0, transfer dropped with no response.
- PRDATA/PSLVERR are ignored when PREADY = 0.

Optional Feature:
- Macro: APB_REQ_TIMEOUT_EN.
- Defined: a counter of ACCESS cycles runs with PREADY = 0 and clears on entering SETUP. When it reaches TIMEOUT_CYCLES, the transfer aborts: move to RESP with PSELx/PENABLE = 0, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0. If PREADY = 1 arrives in the same cycle the count is reached, the normal completion wins.
- Not defined: no counter; ACCESS waits indefinitely; rsp_timeout tied to 0.

Decomposition:
- Package apb_req_pkg: state enum (IDLE, SETUP, ACCESS, RESP), ADDR_W/DATA_W defaults, and address constants ADDR_TX = 0, ADDR_RX = 4, ADDR_CFG = 8, ADDR_TMO = 12.
- One natural sub-module, apb_req_watchdog: a loadable, clearable down-counter for the timeout, instantiated only under the macro.

Test Plan:
- Write with zero wait: cmd write, addr 0x8, data 0x00001ABC, PREADY tied 1 -> PSELx at N+1, PENABLE at N+2, rsp_valid at N+3, rsp_err = 0; completer CONFIG = 0x1ABC.
- Read with wait states: read, addr 0x4, PREADY low for 3 ACCESS cycles then high with PRDATA = 0xDEADBEEF -> PADDR/PSELx/PENABLE stable for 4 ACCESS cycles; rsp_rdata = 0xDEADBEEF.
- Error: write to 0x0 with PSLVERR = 1 at PREADY -> rsp_err = 1, rsp_timeout = 0; PSLVERR = 1 while PREADY = 0 has no effect.
- Backpressure: rsp_ready low 5 cycles -> rsp_valid and rsp_rdata held, cmd_ready = 0, a second cmd_valid is not accepted until the cycle after the handshake.
- Reset mid-ACCESS: PRESET high for 1 cycle during a wait state -> next cycle PSELx = PENABLE = rsp_valid = busy = 0, cmd_ready = 1 after reset deasserts.
- With APB_REQ_TIMEOUT_EN, TIMEOUT_CYCLES = 4, PREADY stuck at 0 -> exactly 4 ACCESS cycles, then rsp_valid with rsp_err = rsp_timeout = 1, rsp_rdata = 0.

Source files
------------

// File: rtl/apb_req_pkg.sv
// Shared types and constants for the APB requester and the I2C completer map.
package apb_req_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  localparam logic [31:0] ADDR_TX  = 32'h0;
  localparam logic [31:0] ADDR_RX  = 32'h4;
  localparam logic [31:0] ADDR_CFG = 32'h8;
  localparam logic [31:0] ADDR_TMO = 32'hC;
endpackage

// File: rtl/apb_requester_if.sv
// Command stream, APB3 bus and response stream of the requester, bundled.
interface apb_requester_if #(
  parameter int ADDR_W = apb_req_pkg::DEF_ADDR_W,
  parameter int DATA_W = apb_req_pkg::DEF_DATA_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready
  );
endinterface

// File: rtl/apb_req_watchdog.sv
// Down-counter for the ACCESS timeout: load on SETUP, decrement on each wait cycle.
module apb_req_watchdog #(
  parameter int LOAD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int W = (LOAD > 1) ? $clog2(LOAD) : 1;

  logic [W-1:0] cnt_q;

  // Holds LOAD-1 so that zero is seen during the LOAD-th wait cycle.
  always_ff @(posedge clk) begin
    if (rst)                     cnt_q <= '0;
    else if (load)               cnt_q <= W'(LOAD - 1);
    else if (dec && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/apb_requester.sv
// APB3 initiator: one command -> SETUP/ACCESS transfer -> one response.
// Optional ACCESS watchdog enabled by APB_REQ_TIMEOUT_EN.
module apb_requester #(
  parameter int ADDR_W         = apb_req_pkg::DEF_ADDR_W,
  parameter int DATA_W         = apb_req_pkg::DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             PCLK,
  input  logic             PRESET,
  apb_requester_if.master  bus,
  output logic             busy
);
  import apb_req_pkg::*;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  state_e            state_q, state_d;
  logic              accept, done, expired;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign done   = (state_q == ACCESS) && bus.PREADY;

`ifdef APB_REQ_TIMEOUT_EN
  logic wd_zero;
  logic tmo_q;

  apb_req_watchdog #(.LOAD(TIMEOUT_CYCLES)) u_wd (
    .clk  (PCLK),
    .rst  (PRESET),
    .load (state_q == SETUP),
    .dec  ((state_q == ACCESS) && !bus.PREADY),
    .zero (wd_zero)
  );

  // A PREADY in the expiry cycle takes priority via done.
  assign expired = (state_q == ACCESS) && !bus.PREADY && wd_zero;

  always_ff @(posedge PCLK) begin
    if (PRESET)       tmo_q <= 1'b0;
    else if (done)    tmo_q <= 1'b0;
    else if (expired) tmo_q <= 1'b1;
  end

  assign bus.rsp_timeout = tmo_q;
`else
  assign expired         = 1'b0;
  assign bus.rsp_timeout = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done || expired) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state_q == IDLE) && !PRESET;
    bus.PSELx     = (state_q == SETUP) || (state_q == ACCESS);
    bus.PENABLE   = (state_q == ACCESS);
    bus.rsp_valid = (state_q == RESP);
    busy          = (state_q != IDLE);
  end

  // Address/data registers only move on acceptance, so they hold in IDLE/RESP.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        pwrite_q <= bus.cmd_write;
        paddr_q  <= bus.cmd_addr;
        pwdata_q <= bus.cmd_wdata;
      end
      if (done) begin
        rdata_q <= pwrite_q ? '0 : bus.PRDATA;
        err_q   <= bus.PSLVERR;
      end else if (expired) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule
